sfq_toggle_rx: RTL

- Digital-side receiver for toggle-encoded SFQ streams, such as the output of a clocked gate like OR2T where every level change marks one pulse.
- Samples a toggle-encoded SFQ clock line and a toggle-encoded data line on the system clock.
- Recovers one bit per SFQ clock window and packs the bits into WIDTH-bit words.
- Presents words on a valid/ready interface. Used in benches and on-chip readout to check gate outputs against expected bit streams.

---
 rtl/sfq_toggle_rx_if.sv | 21 ++
 rtl/sfq_toggle_rx.sv | 116 +++++++++++
 2 files changed

// File: rtl/sfq_toggle_rx_if.sv
// Word output handshake for sfq_toggle_rx: packed word with valid/ready.
// master drives the word; slave consumes it.
interface sfq_toggle_rx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] word_data;
    logic             word_valid;
    logic             word_ready;

    modport master (
        output word_data,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_data,
        input  word_valid,
        output word_ready
    );
endinterface

// File: rtl/sfq_toggle_rx.sv
// Receiver for toggle-encoded SFQ clock/data lines; packs one bit per window into words.
// Define SFQ_RX_SYNC_EN to put a 2-flop synchronizer on both input lines.
module sfq_toggle_rx #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sfq_clk_in,
    input  logic            q_in,
    input  logic            err_clr,
    sfq_toggle_rx_if.master word_if,
    output logic            multi_err,
    output logic            overflow
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             r_s_clk;
    logic             r_s_q;
    logic             r_p_clk;
    logic             r_p_q;
    logic             r_prime;
    logic [1:0]       r_wc;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_merr;
    logic             r_ovf;

    logic             w_ce;
    logic             w_de;
    logic             w_bit;
    logic [WIDTH-1:0] w_shift;
    logic             w_done;
    logic             w_free;
    logic             w_load;
    logic             w_drop;
    logic             w_merr;

`ifdef SFQ_RX_SYNC_EN
    logic [1:0] r_sync_clk;
    logic [1:0] r_sync_q;

    always_ff @(posedge clk) begin
        r_sync_clk <= {r_sync_clk[0], sfq_clk_in};
        r_sync_q   <= {r_sync_q[0], q_in};
        r_s_clk    <= r_sync_clk[1];
        r_s_q      <= r_sync_q[1];
    end
`else
    always_ff @(posedge clk) begin
        r_s_clk <= sfq_clk_in;
        r_s_q   <= q_in;
    end
`endif

    // Sample/prev flops keep tracking the lines through reset so the
    // levels present at release are never mistaken for pulses.
    always_ff @(posedge clk) begin
        r_p_clk <= r_s_clk;
        r_p_q   <= r_s_q;
    end

    assign w_ce    = r_prime & (r_s_clk ^ r_p_clk);
    assign w_de    = r_prime & (r_s_q ^ r_p_q);
    assign w_bit   = (r_wc != 2'd0);
    assign w_shift = LSB_FIRST ? {w_bit, r_sr[WIDTH-1:1]}
                               : {r_sr[WIDTH-2:0], w_bit};
    assign w_done  = w_ce && (r_cnt == CW'(WIDTH - 1));
    assign w_free  = !r_valid || word_if.word_ready;
    assign w_load  = w_done && w_free;
    assign w_drop  = w_done && !w_free;
    assign w_merr  = w_ce && (r_wc == 2'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prime <= 1'b0;
            r_wc    <= 2'd0;
            r_cnt   <= '0;
            r_sr    <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_merr  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_prime <= 1'b1;
            // A data edge coincident with a clock edge opens the new window.
            if (w_ce) begin
                r_wc <= {1'b0, w_de};
                if (w_done) begin
                    r_cnt <= '0;
                    r_sr  <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                    r_sr  <= w_shift;
                end
            end else if (w_de && r_wc != 2'd2) begin
                r_wc <= r_wc + 2'd1;
            end
            if (w_load) begin
                r_data  <= w_shift;
                r_valid <= 1'b1;
            end else if (r_valid && word_if.word_ready) begin
                r_valid <= 1'b0;
            end
            r_merr <= (r_merr & ~err_clr) | w_merr;
            r_ovf  <= (r_ovf & ~err_clr) | w_drop;
        end
    end

    assign word_if.word_data  = r_data;
    assign word_if.word_valid = r_valid;
    assign multi_err          = r_merr;
    assign overflow           = r_ovf;
endmodule
